// File: rtl/multi_strip_driver.sv
// Drives CHANNELS WS2812/SK6812 strips in lockstep from one shared frame RAM.
// One FSM fetches each byte, encodes it MSB first and then holds the lines low for the latch time.
module multi_strip_driver #(
  parameter int CHANNELS       = 4,
  parameter int LEDS_PER_STRIP = 60,
  parameter int BYTES_PER_LED  = 3,
  parameter int BIT_CYCLES     = 15,
  parameter int T0H_CYCLES     = 4,
  parameter int T1H_CYCLES     = 9,
  parameter int LATCH_CYCLES   = 960,
  parameter int READ_LATENCY   = 1,
  parameter int ADDR_W         = $clog2(LEDS_PER_STRIP*BYTES_PER_LED)
) (
  input  logic                  clock_12mhz,
  input  logic                  reset_n,
  input  logic                  frame_start,
  input  logic [CHANNELS-1:0]   channel_enable,
  output logic                  read_enable,
  output logic [ADDR_W-1:0]     read_address,
  input  logic [8*CHANNELS-1:0] read_data,
  output logic [CHANNELS-1:0]   strip,
  output logic                  busy,
  output logic                  frame_done,
  output logic [1:0]            state_dbg
);

  localparam int PH_W = $clog2(BIT_CYCLES);
  localparam int LC_W = $clog2(LATCH_CYCLES + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(LEDS_PER_STRIP*BYTES_PER_LED - 1);
  localparam logic [PH_W-1:0]   PH_LAST   = PH_W'(BIT_CYCLES - 1);
  localparam logic [PH_W-1:0]   T0H_P     = PH_W'(T0H_CYCLES);
  localparam logic [PH_W-1:0]   T1H_P     = PH_W'(T1H_CYCLES);
  localparam logic [PH_W-1:0]   CAP_PH    = PH_W'(READ_LATENCY);
  localparam logic [LC_W-1:0]   LC_LAST   = LC_W'(LATCH_CYCLES);
  localparam logic [1:0]        FETCH_END = 2'(READ_LATENCY);

  if (!(T0H_CYCLES < T1H_CYCLES && T1H_CYCLES < BIT_CYCLES)) begin : g_bad_timing
    $error("multi_strip_driver: need T0H_CYCLES < T1H_CYCLES < BIT_CYCLES");
  end
  if (BIT_CYCLES <= READ_LATENCY + 2) begin : g_bad_bit_len
    $error("multi_strip_driver: BIT_CYCLES must exceed READ_LATENCY+2");
  end
  if (READ_LATENCY < 1 || READ_LATENCY > 2) begin : g_bad_latency
    $error("multi_strip_driver: READ_LATENCY must be 1 or 2");
  end

  typedef enum logic [1:0] {IDLE, FETCH, SEND, LATCH} state_t;
  state_t state, next_state;

  logic [CHANNELS-1:0]      en_q;
  logic [CHANNELS-1:0][7:0] sh;
  logic [CHANNELS-1:0][7:0] hold;
  logic [CHANNELS-1:0][7:0] rd_bytes;
  logic [PH_W-1:0]          phase;
  logic [2:0]               bit_idx;
  logic [ADDR_W-1:0]        addr_q;
  logic [1:0]               fetch_cnt;
  logic [LC_W-1:0]          latch_cnt;

  logic accept, fetch_done, bit_end, byte_end, last_byte, prefetch, capture, latch_end;

  assign rd_bytes = read_data;

  always_comb begin
    accept     = (state == IDLE) && frame_start;
    fetch_done = (state == FETCH) && (fetch_cnt == FETCH_END);
    bit_end    = (phase == PH_LAST);
    byte_end   = (state == SEND) && bit_end && (bit_idx == 3'd7);
    last_byte  = (addr_q == LAST_ADDR);
    // The next byte is requested at the start of bit 7 so it is ready before the current byte ends.
    prefetch   = (state == SEND) && (bit_idx == 3'd7) && (phase == '0) && !last_byte;
    capture    = (state == SEND) && (bit_idx == 3'd7) && (phase == CAP_PH) && !last_byte;
    latch_end  = (state == LATCH) && (latch_cnt == LC_LAST);
  end

  always_ff @(posedge clock_12mhz) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = FETCH;
      FETCH:   if (fetch_done) next_state = SEND;
      SEND:    if (byte_end && last_byte) next_state = LATCH;
      LATCH:   if (latch_end) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    busy         = (state != IDLE);
    frame_done   = latch_end;
    read_enable  = ((state == FETCH) && (fetch_cnt == 2'd0)) || prefetch;
    read_address = prefetch ? addr_q + ADDR_W'(1) : addr_q;
    state_dbg    = state;
  end

  always_ff @(posedge clock_12mhz) begin
    if (!reset_n) begin
      en_q      <= '0;
      sh        <= '0;
      hold      <= '0;
      phase     <= '0;
      bit_idx   <= '0;
      addr_q    <= '0;
      fetch_cnt <= '0;
      latch_cnt <= '0;
      strip     <= '0;
    end else begin
      if (accept) begin
        en_q      <= channel_enable;
        addr_q    <= '0;
        fetch_cnt <= '0;
      end
      if (state == FETCH) begin
        fetch_cnt <= fetch_cnt + 2'd1;
        if (fetch_done) begin
          sh      <= rd_bytes;
          phase   <= '0;
          bit_idx <= '0;
        end
      end
      if (state == SEND) begin
        if (capture) hold <= rd_bytes;
        if (bit_end) begin
          phase   <= '0;
          bit_idx <= bit_idx + 3'd1;
          if (bit_idx == 3'd7) begin
            if (!last_byte) begin
              sh     <= hold;
              addr_q <= addr_q + ADDR_W'(1);
            end
          end else begin
            for (int c = 0; c < CHANNELS; c++) sh[c] <= {sh[c][6:0], 1'b0};
          end
        end else begin
          phase <= phase + PH_W'(1);
        end
      end
      if (state == LATCH) latch_cnt <= latch_cnt + LC_W'(1);
      else                latch_cnt <= '0;
      // Lines are registered, so the waveform trails the SEND bookkeeping by one cycle.
      for (int c = 0; c < CHANNELS; c++)
        strip[c] <= (state == SEND) && en_q[c] && (phase < (sh[c][7] ? T1H_P : T0H_P));
    end
  end

endmodule

// File: tb/tb_multi_strip_driver.sv
// Directed bench for multi_strip_driver: 2 LEDs x 3 bytes x 4 channels, memory latency 1.
module tb_multi_strip_driver;

  localparam int CH = 4;
  localparam int NB = 6;
  localparam int FIRST_HI = 3;
  localparam int DATA_END = FIRST_HI + NB*8*15;
  localparam int DONE_K = 3 + 720 + 960 - 1;

  logic          clk = 0;
  logic          reset_n = 0;
  logic          frame_start = 0;
  logic [CH-1:0] channel_enable = '0;
  logic          read_enable;
  logic [2:0]    read_address;
  logic [31:0]   read_data = '0;
  logic [CH-1:0] strip;
  logic          busy;
  logic          frame_done;
  logic [1:0]    state_dbg;

  int checks = 0;
  int errors = 0;
  logic [2:0] exp_q[$];
  logic [31:0] mem_word [NB];

  typedef struct packed {
    logic [NB-1:0][31:0] mem;
    logic [CH-1:0]       en;
    logic [CH-1:0][15:0] hi;
  } vec_t;
  vec_t vecs [4];

  always #5 clk = ~clk;

  multi_strip_driver #(.CHANNELS(CH), .LEDS_PER_STRIP(2), .BYTES_PER_LED(3)) dut (
    .clock_12mhz(clk), .reset_n(reset_n), .frame_start(frame_start),
    .channel_enable(channel_enable), .read_enable(read_enable),
    .read_address(read_address), .read_data(read_data), .strip(strip),
    .busy(busy), .frame_done(frame_done), .state_dbg(state_dbg)
  );

  always @(posedge clk)
    if (read_enable) read_data <= (read_address < 3'd6) ? mem_word[read_address] : 32'hDEADBEEF;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_read();
    logic [2:0] a;
    if (read_enable === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("read_extra", {29'd0, read_address}, 32'hFFFFFFFF);
      end else begin
        a = exp_q.pop_front();
        check("read_addr", {29'd0, read_address}, {29'd0, a});
      end
    end
  endtask

  function automatic logic exp_strip(input int v, input int c, input int k);
    int j, p;
    logic [31:0] w;
    logic b;
    if (k < FIRST_HI || k >= DATA_END) return 1'b0;
    j = (k - FIRST_HI) / 15;
    p = (k - FIRST_HI) % 15;
    w = vecs[v].mem[j/8];
    b = w[8*c + 7 - (j % 8)];
    return vecs[v].en[c] && (p < (b ? 9 : 4));
  endfunction

  task automatic start_frame(input int v);
    for (int a = 0; a < NB; a++) mem_word[a] = vecs[v].mem[a];
    exp_q.delete();
    for (int a = 0; a < NB; a++) exp_q.push_back(3'(a));
    @(negedge clk);
    frame_start = 1'b1;
    channel_enable = vecs[v].en;
    @(negedge clk);
    frame_start = 1'b0;
    channel_enable = ~vecs[v].en;
  endtask

  task automatic run_frame(input int v, input bit inject);
    int wave_err [CH];
    int hi_cnt [CH];
    int fd_k;
    for (int c = 0; c < CH; c++) begin wave_err[c] = 0; hi_cnt[c] = 0; end
    fd_k = -1;
    start_frame(v);
    check($sformatf("v%0d busy_at_start", v), {31'd0, busy}, 32'd1);
    for (int k = 0; k < 2000; k++) begin
      check_read();
      for (int c = 0; c < CH; c++) begin
        if (strip[c] !== exp_strip(v, c, k)) wave_err[c]++;
        if (strip[c] === 1'b1) hi_cnt[c]++;
      end
      frame_start = inject && (k == 100);
      if (frame_done === 1'b1) begin
        fd_k = k;
        frame_start = inject;
        break;
      end
      @(negedge clk);
    end
    check($sformatf("v%0d frame_done_cycle", v), fd_k, DONE_K);
    check($sformatf("v%0d busy_on_done", v), {31'd0, busy}, 32'd1);
    @(negedge clk);
    frame_start = 1'b0;
    check($sformatf("v%0d busy_after_done", v), {31'd0, busy}, 32'd0);
    check($sformatf("v%0d done_pulse_width", v), {31'd0, frame_done}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      check_read();
      @(negedge clk);
    end
    check($sformatf("v%0d still_idle", v), {31'd0, busy}, 32'd0);
    check($sformatf("v%0d reads_left", v), exp_q.size(), 0);
    for (int c = 0; c < CH; c++) begin
      check($sformatf("v%0d wave_ch%0d", v, c), wave_err[c], 0);
      check($sformatf("v%0d high_cycles_ch%0d", v, c), hi_cnt[c], {16'd0, vecs[v].hi[c]});
    end
  endtask

  initial begin
    // Bit timing: ch0 byte0 = A5 (4 ones), everything else zero.
    vecs[0].mem = '0;
    vecs[0].mem[0] = 32'h000000A5;
    vecs[0].en = 4'hF;
    vecs[0].hi = {16'd192, 16'd192, 16'd192, 16'd212};
    // Parallel data: ch0=00, ch1=FF, ch2=0F, ch3=F0 on every byte.
    for (int a = 0; a < NB; a++) vecs[1].mem[a] = 32'hF00FFF00;
    vecs[1].en = 4'hF;
    vecs[1].hi = {16'd312, 16'd312, 16'd432, 16'd192};
    // Same data with channels 0 and 2 disabled.
    vecs[2].mem = vecs[1].mem;
    vecs[2].en = 4'b1010;
    vecs[2].hi = {16'd312, 16'd0, 16'd432, 16'd0};
    // Distinct bytes per address on ch0, ch2 all ones.
    vecs[3].mem[0] = 32'h00FF0001;
    vecs[3].mem[1] = 32'h00FF0080;
    vecs[3].mem[2] = 32'h00FF0055;
    vecs[3].mem[3] = 32'h00FF00AA;
    vecs[3].mem[4] = 32'h00FF00FE;
    vecs[3].mem[5] = 32'h00FF007F;
    vecs[3].en = 4'hF;
    vecs[3].hi = {16'd192, 16'd432, 16'd192, 16'd312};

    repeat (3) @(negedge clk);
    check("reset_strip", {28'd0, strip}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, frame_done}, 32'd0);
    check("reset_rd_en", {31'd0, read_enable}, 32'd0);
    check("reset_rd_addr", {29'd0, read_address}, 32'd0);
    check("reset_state", {30'd0, state_dbg}, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 4; v++) run_frame(v, v == 3);

    // Reset in the middle of byte 3 aborts the frame immediately.
    start_frame(1);
    for (int k = 0; k < 370; k++) begin
      check_read();
      @(negedge clk);
    end
    check("pre_reset_busy", {31'd0, busy}, 32'd1);
    reset_n = 1'b0;
    @(negedge clk);
    check("midreset_strip", {28'd0, strip}, 32'd0);
    check("midreset_busy", {31'd0, busy}, 32'd0);
    check("midreset_done", {31'd0, frame_done}, 32'd0);
    check("midreset_rd_en", {31'd0, read_enable}, 32'd0);
    check("midreset_rd_addr", {29'd0, read_address}, 32'd0);
    reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (busy !== 1'b0 || strip !== '0 || frame_done !== 1'b0) check("post_reset_quiet", 32'd1, 32'd0);
      @(negedge clk);
    end
    run_frame(0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
